// File: rtl/lfsr_checker.sv
// lfsr_checker
// Receive-side checker for the 4-bit LFSR pattern generator.
// It hunts for a non-zero word and follows the sequence until
// LOCK_COUNT consecutive words agree with the prediction. It then
// free-runs its own prediction, pulses err on every mismatch and
// keeps a saturating error count. UNLOCK_COUNT consecutive misses
// drop it back to hunting.
// The generator recurrence is next(x) = {x[2:0], x[3]^x[2]}.
// This gives a period of 15, and the all-zero word never occurs.

module lfsr_checker #(
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 3,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [3:0]       data_in,
   input  logic             clr_count,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count
);

   // The counters are sized so they can hold their terminal value.
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);

   localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(LOCK_COUNT);
   localparam logic [MISS_W-1:0]  MISS_TGT  = MISS_W'(UNLOCK_COUNT);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         pred_q, pred_d;
   logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
   logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
   logic               locked_q, locked_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   err_count_q, err_count_d;

   logic               isMatch;
   logic               dataZero;
   logic [MATCH_W-1:0] matchInc;
   logic [MISS_W-1:0]  missInc;

   // This is one step of the generator recurrence.
   function automatic logic [3:0] nextWord(input logic [3:0] x);
      return {x[2:0], x[3] ^ x[2]};
   endfunction

   assign isMatch  = (data_in == pred_q);
   assign dataZero = (data_in == 4'd0);
   assign matchInc = match_cnt_q + MATCH_W'(1);
   assign missInc  = miss_cnt_q + MISS_W'(1);

   // The state register holds the FSM, the prediction, the run counters and the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HUNT;
         pred_q      <= 4'd0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         pred_q      <= pred_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   // The next-state logic moves through hunt, sync and locked on each valid sample and nothing moves while en is low.
   always_comb begin
      state_d     = state_q;
      pred_d      = pred_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      if (en) begin
         case (state_q)
            HUNT: begin
               if (!dataZero) begin
                  pred_d      = nextWord(data_in);
                  match_cnt_d = MATCH_W'(1);
                  miss_cnt_d  = '0;
                  state_d     = (LOCK_COUNT == 1) ? LOCKED : SYNC;
               end
            end
            SYNC: begin
               if (isMatch) begin
                  pred_d      = nextWord(pred_q);
                  match_cnt_d = matchInc;
                  if (matchInc == MATCH_TGT) begin
                     state_d    = LOCKED;
                     miss_cnt_d = '0;
                  end
               end else if (!dataZero) begin
                  pred_d      = nextWord(data_in);
                  match_cnt_d = MATCH_W'(1);
               end else begin
                  state_d     = HUNT;
                  match_cnt_d = '0;
               end
            end
            LOCKED: begin
               // Once locked, the prediction free-runs and is never reloaded from the received data.
               pred_d = nextWord(pred_q);
               if (isMatch) begin
                  miss_cnt_d = '0;
               end else if (missInc == MISS_TGT) begin
                  state_d     = HUNT;
                  miss_cnt_d  = '0;
                  match_cnt_d = '0;
               end else begin
                  miss_cnt_d = missInc;
               end
            end
            default: begin
               state_d     = HUNT;
               match_cnt_d = '0;
               miss_cnt_d  = '0;
            end
         endcase
      end
   end

   // The output logic computes the registered outputs: lock flag, error pulse and the saturating count, where a clear beats an increment.
   always_comb begin
      locked_d    = (state_d == LOCKED);
      err_d       = en && (state_q == LOCKED) && !isMatch;
      err_count_d = err_count_q;
      if (clr_count) begin
         err_count_d = '0;
      end else if (err_d && (err_count_q != CNT_MAX)) begin
         err_count_d = err_count_q + CNT_W'(1);
      end
   end

   assign locked    = locked_q;
   assign err       = err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
// Directed and randomized bench for lfsr_checker. Two instances are used:
// one with default parameters, and one with CNT_W=2 and UNLOCK_COUNT=8 for
// saturation. A behavioural model based on the 15-entry sequence table tracks
// the active instance.

module tb_lfsr_checker;

   logic       clk;
   logic       rstA, rstB;
   logic       en;
   logic [3:0] dataIn;
   logic       clrCount;
   logic       lockedA, errA, lockedB, errB;
   logic [7:0] errCountA;
   logic [1:0] errCountB;

   int total = 0;
   int bad   = 0;

   // The model state is tracked as a position in the sequence table and run lengths.
   logic [3:0] seqTab [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                               4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
   bit  activeB = 0;
   int  lockN   = 4;
   int  unlockN = 3;
   int  maxCnt  = 255;
   bit  mLocked;
   int  mRun;
   int  mMiss;
   int  mIdx;
   bit  mErr;
   int  mCount;

   lfsr_checker dutA (
      .clk(clk), .rst(rstA), .en(en), .data_in(dataIn), .clr_count(clrCount),
      .locked(lockedA), .err(errA), .err_count(errCountA)
   );

   lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(8), .CNT_W(2)) dutB (
      .clk(clk), .rst(rstB), .en(en), .data_in(dataIn), .clr_count(clrCount),
      .locked(lockedB), .err(errB), .err_count(errCountB)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic int posOf(input logic [3:0] x);
      for (int i = 0; i < 15; i++) if (seqTab[i] == x) return i;
      return 0;
   endfunction

   // The model advances by one clock edge. A run of 0 while unlocked means the model is hunting.
   task automatic modelStep(input bit r, input bit e, input logic [3:0] d, input bit c);
      if (r) begin
         mLocked = 0; mRun = 0; mMiss = 0; mIdx = 0; mErr = 0; mCount = 0;
         return;
      end
      mErr = 0;
      if (e) begin
         if (mLocked) begin
            if (d != seqTab[mIdx]) begin
               mErr = 1;
               if (mCount < maxCnt) mCount++;
               mMiss++;
               if (mMiss == unlockN) begin
                  mLocked = 0; mRun = 0; mMiss = 0;
               end
            end else begin
               mMiss = 0;
            end
            mIdx = (mIdx + 1) % 15;
         end else if (mRun == 0) begin
            if (d != 0) begin
               mIdx = (posOf(d) + 1) % 15; mRun = 1; mMiss = 0;
               if (mRun >= lockN) mLocked = 1;
            end
         end else begin
            if (d == seqTab[mIdx]) begin
               mIdx = (mIdx + 1) % 15; mRun++;
               if (mRun >= lockN) begin mLocked = 1; mMiss = 0; end
            end else if (d != 0) begin
               mIdx = (posOf(d) + 1) % 15; mRun = 1;
            end else begin
               mRun = 0;
            end
         end
      end
      if (c) mCount = 0;
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      if (activeB) begin
         cmp({tag, ".locked"}, {31'd0, lockedB}, {31'd0, mLocked});
         cmp({tag, ".err"}, {31'd0, errB}, {31'd0, mErr});
         cmp({tag, ".count"}, {30'd0, errCountB}, mCount);
      end else begin
         cmp({tag, ".locked"}, {31'd0, lockedA}, {31'd0, mLocked});
         cmp({tag, ".err"}, {31'd0, errA}, {31'd0, mErr});
         cmp({tag, ".count"}, {24'd0, errCountA}, mCount);
      end
   endtask

   // Inputs are driven on the falling edge and outputs are checked 1 ns after the rising edge.
   task automatic applyStimulus(input string tag, input bit r, input bit e,
                                input logic [3:0] d, input bit c);
      @(negedge clk);
      rstA = activeB ? 1'b1 : r;
      rstB = activeB ? r : 1'b1;
      en = e; dataIn = d; clrCount = c;
      @(posedge clk);
      modelStep(r, e, d, c);
      #1;
      checkOutput(tag);
   endtask

   task automatic sendWords(input string tag, input logic [3:0] w [$]);
      foreach (w[i]) applyStimulus(tag, 0, 1, w[i], 0);
   endtask

   initial begin
      int genIdx;
      rstA = 1; rstB = 1; en = 0; dataIn = 0; clrCount = 0;

      // Reset state
      applyStimulus("reset", 1, 0, 4'h0, 0);
      cmp("reset.lockedA", {31'd0, lockedA}, 0);
      cmp("reset.countA", {24'd0, errCountA}, 0);

      // 1. basic lock
      sendWords("lock", '{4'h1, 4'h2, 4'h4, 4'h9});
      cmp("lock.locked", {31'd0, lockedA}, 1);
      cmp("lock.count", {24'd0, errCountA}, 0);

      // 2. single error while locked
      sendWords("single", '{4'h3, 4'h6});
      applyStimulus("single0", 0, 1, 4'h0, 0);
      cmp("single.errPulse", {31'd0, errA}, 1);
      applyStimulus("singleA", 0, 1, 4'hA, 0);
      cmp("single.errCleared", {31'd0, errA}, 0);
      cmp("single.count", {24'd0, errCountA}, 1);
      cmp("single.stillLocked", {31'd0, lockedA}, 1);

      // 3. loss of lock, then relock
      sendWords("loss", '{4'h1, 4'h1, 4'h1});
      cmp("loss.count", {24'd0, errCountA}, 4);
      cmp("loss.unlocked", {31'd0, lockedA}, 0);
      sendWords("relock", '{4'h1, 4'h2, 4'h4});
      cmp("relock.notYet", {31'd0, lockedA}, 0);
      sendWords("relock", '{4'h9});
      cmp("relock.locked", {31'd0, lockedA}, 1);

      // 4. hunt and sync restart
      applyStimulus("restartRst", 1, 0, 4'h0, 0);
      sendWords("restart", '{4'h0, 4'h0, 4'h1, 4'h2, 4'h5, 4'hB, 4'h7});
      cmp("restart.notYet", {31'd0, lockedA}, 0);
      sendWords("restart", '{4'hF});
      cmp("restart.locked", {31'd0, lockedA}, 1);
      cmp("restart.count", {24'd0, errCountA}, 0);

      // 5. en gating, then reset mid-lock
      for (int i = 0; i < 5; i++) applyStimulus("gate", 0, 0, 4'($urandom), 0);
      applyStimulus("gateNext", 0, 1, 4'hE, 0);
      cmp("gate.matchLocked", {31'd0, lockedA}, 1);
      cmp("gate.matchNoErr", {31'd0, errA}, 0);
      applyStimulus("midRst", 1, 1, 4'h3, 0);
      cmp("midRst.locked", {31'd0, lockedA}, 0);

      // 6. saturation and clear on the narrow instance
      activeB = 1; unlockN = 8; maxCnt = 3;
      applyStimulus("satRst", 1, 0, 4'h0, 0);
      sendWords("satLock", '{4'h1, 4'h2, 4'h4, 4'h9});
      for (int i = 0; i < 5; i++) applyStimulus("satErr", 0, 1, 4'h0, 0);
      cmp("sat.count", {30'd0, errCountB}, 3);
      cmp("sat.locked", {31'd0, lockedB}, 1);
      applyStimulus("satClr", 0, 1, 4'h0, 1);
      cmp("satClr.count", {30'd0, errCountB}, 0);
      cmp("satClr.err", {31'd0, errB}, 1);

      // Randomized traffic on the default instance, mostly on-sequence with occasional corruption
      activeB = 0; unlockN = 3; maxCnt = 255;
      applyStimulus("rndRst", 1, 0, 4'h0, 0);
      genIdx = $urandom_range(0, 14);
      for (int i = 0; i < 400; i++) begin
         bit e;
         bit c;
         logic [3:0] d;
         e = ($urandom_range(0, 9) < 8);
         c = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 9) < 8) d = seqTab[genIdx];
         else d = 4'($urandom);
         if ($urandom_range(0, 49) == 0) genIdx = $urandom_range(0, 14);
         if (e) genIdx = (genIdx + 1) % 15;
         applyStimulus("random", ($urandom_range(0, 199) == 0), e, d, c);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
